// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types for the cacheline <-> 4-beat burst adaptor.
// Beat type, line geometry constants and adaptor FSM state encoding.
package cacheline_burst_adaptor_pkg;

    typedef logic [63:0] rv32i_beat;

    localparam int BEATS_PER_LINE   = 4;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } adaptor_state_t;

    function automatic logic in_burst(input adaptor_state_t s);
        return (s == RD_BURST) || (s == WR_BURST);
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_shreg.sv
// cl_beat_shreg: line-wide beat shift register shared by read and write paths.
// Parallel load / serial beat out at entry 0; serial beat in at the top entry / parallel line out.
module cl_beat_shreg #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LINE_W-1:0] line_in,
    input  logic              shift,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [BEAT_W-1:0] beat_out,
    output logic [LINE_W-1:0] line_out
);

    localparam int BEATS = LINE_W / BEAT_W;

    logic [BEAT_W-1:0] entry_reg  [BEATS];
    logic [BEAT_W-1:0] entry_next [BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_entry
            logic [BEAT_W-1:0] shift_src;
            // Shifting moves every beat one slot toward entry 0; the top slot takes the serial input.
            if (gi == BEATS - 1) begin : g_top
                assign shift_src = beat_in;
            end else begin : g_mid
                assign shift_src = entry_reg[gi+1];
            end
            assign entry_next[gi] = load  ? line_in[gi*BEAT_W +: BEAT_W] :
                                    shift ? shift_src : entry_reg[gi];
            assign line_out[gi*BEAT_W +: BEAT_W] = entry_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < BEATS; i++) begin
            if (reset) begin
                entry_reg[i] <= '0;
            end else begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign beat_out = entry_reg[0];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cacheline read/write into a 4-beat burst and reassembles read beats into a line.
// Optional macro CL_ADAPTOR_STATS_EN adds read/write/stall statistics counters.
module cacheline_burst_adaptor
    import cacheline_burst_adaptor_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] line_addr_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [ADDR_W-1:0] burst_addr_o,
    output logic [BEAT_W-1:0] burst_wdata_o,
    output logic              burst_read_o,
    output logic              burst_write_o,
    input  logic [BEAT_W-1:0] burst_rdata_i,
    input  logic              burst_resp_i
`ifdef CL_ADAPTOR_STATS_EN
    ,
    output logic [31:0]       stat_reads_o,
    output logic [31:0]       stat_writes_o,
    output logic [31:0]       stat_stall_o
`endif
);

    localparam int CNT_W = $clog2(BEATS_PER_LINE);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((2 ** LINE_OFFSET_BITS) - 1);

    adaptor_state_t    state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rd_reg, rd_next;
    logic              wr_reg, wr_next;
    logic              resp_reg, resp_next;
    logic [LINE_W-1:0] rdata_reg, rdata_next;

    logic              shreg_load;
    logic              shreg_shift;
    logic [BEAT_W-1:0] shreg_ser_in;
    logic [BEAT_W-1:0] shreg_beat;
    logic [LINE_W-1:0] shreg_line;

    cl_beat_shreg #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (shreg_load),
        .line_in  (line_wdata_i),
        .shift    (shreg_shift),
        .beat_in  (shreg_ser_in),
        .beat_out (shreg_beat),
        .line_out (shreg_line)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            resp_reg  <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            resp_reg  <= resp_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        rd_next      = 1'b0;
        wr_next      = 1'b0;
        resp_next    = 1'b0;
        rdata_next   = rdata_reg;
        shreg_load   = 1'b0;
        shreg_shift  = 1'b0;
        shreg_ser_in = '0;
        case (state_reg)
            IDLE: begin
                // Write wins when both requests are (illegally) raised together.
                if (line_write_i) begin
                    state_next = WR_BURST;
                    wr_next    = 1'b1;
                    addr_next  = line_addr_i & LINE_MASK;
                    cnt_next   = '0;
                    shreg_load = 1'b1;
                end else if (line_read_i) begin
                    state_next = RD_BURST;
                    rd_next    = 1'b1;
                    addr_next  = line_addr_i & LINE_MASK;
                    cnt_next   = '0;
                end
            end
            RD_BURST: begin
                rd_next = 1'b1;
                if (burst_resp_i) begin
                    shreg_shift  = 1'b1;
                    shreg_ser_in = burst_rdata_i;
                    cnt_next     = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        // Final beat lands straight in the output line, skipping the shift register.
                        state_next = RD_DONE;
                        rd_next    = 1'b0;
                        resp_next  = 1'b1;
                        rdata_next = {burst_rdata_i, shreg_line[LINE_W-1:BEAT_W]};
                    end
                end
            end
            WR_BURST: begin
                wr_next = 1'b1;
                if (burst_resp_i) begin
                    shreg_shift = 1'b1;
                    cnt_next    = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = WR_DONE;
                        wr_next    = 1'b0;
                        resp_next  = 1'b1;
                    end
                end
            end
            RD_DONE, WR_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign line_rdata_o  = rdata_reg;
    assign line_resp_o   = resp_reg;
    assign burst_addr_o  = addr_reg;
    assign burst_wdata_o = shreg_beat;
    assign burst_read_o  = rd_reg;
    assign burst_write_o = wr_reg;

`ifdef CL_ADAPTOR_STATS_EN
    logic [31:0] reads_reg, writes_reg, stall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            reads_reg  <= '0;
            writes_reg <= '0;
            stall_reg  <= '0;
        end else begin
            if (state_reg == RD_BURST && state_next == RD_DONE) begin
                reads_reg <= reads_reg + 32'd1;
            end
            if (state_reg == WR_BURST && state_next == WR_DONE) begin
                writes_reg <= writes_reg + 32'd1;
            end
            if (in_burst(state_reg) && !burst_resp_i) begin
                stall_reg <= stall_reg + 32'd1;
            end
        end
    end

    assign stat_reads_o  = reads_reg;
    assign stat_writes_o = writes_reg;
    assign stat_stall_o  = stall_reg;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && state_reg == IDLE) begin
            assert (!(line_read_i && line_write_i))
            else $warning("cacheline_burst_adaptor: read and write requested together in IDLE, servicing write");
        end
    end
`endif

endmodule
